ps2_rx_frame: RTL

PS2_RX_FRAME -- requirements
Module: ps2_rx_frame

---
 rtl/ps2_pkg.sv | 15 +
 rtl/ps2_sync_filter.sv | 56 +++++
 rtl/ps2_rx_frame.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types: frame-decoder state encoding and default timing constants.
// Pure declarations; no logic, no latency, no backpressure.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam int FILTER_LEN_DEF     = 8;
  localparam int TIMEOUT_CYCLES_DEF = 100000;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser for one PS/2 line, optionally followed by a run-length glitch filter.
// Latency: 2 cycles synchronised, plus FILTER_LEN cycles when filtered; no backpressure.
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF,
  parameter bit BYPASS     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic s1_q;
  logic s2_q;

  // Flops come out of reset at the idle-high bus level so no edge is seen on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

  generate
    if (BYPASS) begin : g_bypass
      assign dout = s2_q;
    end else begin : g_filt
      localparam int CW = $clog2(FILTER_LEN + 1);
      logic [CW-1:0] cnt_q;
      logic          filt_q;

      // cnt_q counts consecutive samples that disagree with the current filtered level.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q  <= '0;
          filt_q <= 1'b1;
        end else if (s2_q == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
          cnt_q  <= '0;
          filt_q <= s2_q;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      assign dout = filt_q;
    end
  endgenerate

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: start, 8 data LSB first, odd parity, stop; one result strobe per frame.
// Latency: strobe 2 + FILTER_LEN + 1 cycles after the raw stop-bit clock fall; no backpressure (strobes only).
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_f;
  logic dat_s;
  logic clk_f_prev_q;
  logic fall;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN), .BYPASS(1'b0)) u_clk_filt (
    .clk   (clk),
    .reset (reset),
    .din   (ps2_clk_i),
    .dout  (clk_f)
  );

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN), .BYPASS(1'b1)) u_dat_sync (
    .clk   (clk),
    .reset (reset),
    .din   (ps2_dat_i),
    .dout  (dat_s)
  );

  assign fall = clk_f_prev_q & ~clk_f;

  ps2_state_t      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_ok_q, par_ok_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            valid_q, valid_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_f_prev_q <= 1'b1;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_ok_q     <= 1'b0;
      to_cnt_q     <= '0;
      rx_data_q    <= '0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      clk_f_prev_q <= clk_f;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_ok_q     <= par_ok_d;
      to_cnt_q     <= to_cnt_d;
      rx_data_q    <= rx_data_d;
      valid_q      <= valid_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
    end
  end

  // Fires on the cycle the counter would reach TIMEOUT_CYCLES; a coincident edge takes priority.
  assign timeout = (state_q != ST_IDLE) && !fall &&
                   (to_cnt_q >= TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    rx_data_d = rx_data_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    to_cnt_d  = to_cnt_q;

    if (state_q == ST_IDLE || fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (fall && !dat_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_ok_d = ^{shift_q, dat_s};
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_d = ST_IDLE;
          if (!dat_s) begin
            ferr_d = 1'b1;
          end else if (par_ok_q) begin
            valid_d   = 1'b1;
            rx_data_d = shift_q;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout) begin
      state_d = ST_IDLE;
      ferr_d  = 1'b1;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
